// File: rtl/bundle_decoder.sv
// bundle_decoder
//   Watches the N-line output bundle of a NAND-multiplexing stage over a
//   window of WINDOW consecutive samples. It sums the stimulated lines and
//   classifies the window by the von Neumann thresholds. It also counts the
//   samples whose own classification differs from the expected logic value.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start_i      request a window (accepted only in IDLE)
//   expected_i   expected logic value, latched when start is accepted
//   bundle_i     N-bit bundle under test
//   busy_o       high while accumulating and in the DONE cycle
//   done_o       one-cycle pulse; results are valid from this cycle
//   value_o      window classification (0 when undecided)
//   undecided_o  window total strictly between the thresholds
//   total_o      sum of ones over the window
//   sample_err_o samples misclassified against expected (undecided = error)
//
// Optional build: define BUNDLE_DECODER_STATS_EN to add undecided_runs_o, a
// 16-bit saturating count of windows that ended undecided (cleared by reset).
//
// Handshake: start_i is a request that is taken only in IDLE. There is no
// ready signal and requests are not queued. busy_o low means the block will
// accept start_i in that cycle. done_o marks the first cycle in which the
// results are valid. The results then hold until the next done_o or reset.

module bundle_decoder #(
  parameter int N        = 10,
  parameter int WINDOW   = 16,
  parameter int HI_LINES = 9,
  parameter int LO_LINES = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_i,
  input  logic                               expected_i,
  input  logic [N-1:0]                       bundle_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               value_o,
  output logic                               undecided_o,
  output logic [$clog2(N*WINDOW+1)-1:0]      total_o,
  output logic [$clog2(WINDOW+1)-1:0]        sample_err_o
`ifdef BUNDLE_DECODER_STATS_EN
  ,
  output logic [15:0]                        undecided_runs_o
`endif
);

  localparam int TW = $clog2(N*WINDOW+1);
  localparam int EW = $clog2(WINDOW+1);
  localparam int PW = $clog2(N+1);
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  // Window thresholds are compared in 32 bits so the products never truncate.
  localparam int unsigned HI_THR = HI_LINES * WINDOW;
  localparam int unsigned LO_THR = LO_LINES * WINDOW;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  sum_q, sum_d;
  logic [EW-1:0]  err_q, err_d;
  logic           exp_q, exp_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           value_q, value_d;
  logic           undec_q, undec_d;
  logic [TW-1:0]  total_q, total_d;
  logic [EW-1:0]  serr_q, serr_d;

  logic [PW-1:0]  ones;
  logic           samp_one, samp_zero, samp_err;
  logic [TW-1:0]  sum_next;
  logic [EW-1:0]  err_next;

  // Popcount of the current bundle and the classification of this sample.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) ones = ones + PW'(bundle_i[i]);
    samp_one  = (32'(ones) >= 32'(HI_LINES));
    samp_zero = (32'(ones) <= 32'(LO_LINES));
    // An undecided sample is neither one nor zero, so it is always an error.
    samp_err  = exp_q ? !samp_one : !samp_zero;
    sum_next  = sum_q + TW'(ones);
    err_next  = err_q + EW'(samp_err);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    err_d   = err_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    value_d = value_q;
    undec_d = undec_q;
    total_d = total_q;
    serr_d  = serr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          exp_d   = expected_i;
          sum_d   = '0;
          err_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        sum_d = sum_next;
        err_d = err_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WINDOW - 1)) begin
          // Register the results now so that they are valid during DONE.
          state_d = ST_DONE;
          done_d  = 1'b1;
          total_d = sum_next;
          serr_d  = err_next;
          value_d = (32'(sum_next) >= HI_THR);
          undec_d = (32'(sum_next) < HI_THR) && (32'(sum_next) > LO_THR);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= '0;
      exp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      value_q <= 1'b0;
      undec_q <= 1'b0;
      total_q <= '0;
      serr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      value_q <= value_d;
      undec_q <= undec_d;
      total_q <= total_d;
      serr_q  <= serr_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign value_o      = value_q;
  assign undecided_o  = undec_q;
  assign total_o      = total_q;
  assign sample_err_o = serr_q;

`ifdef BUNDLE_DECODER_STATS_EN
  logic [15:0] runs_q, runs_d;

  // Count once per undecided DONE cycle and stick at all-ones.
  always_comb begin
    runs_d = runs_q;
    if (state_q == ST_DONE && undec_q && runs_q != 16'hFFFF)
      runs_d = runs_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) runs_q <= '0;
    else       runs_q <= runs_d;
  end

  assign undecided_runs_o = runs_q;
`endif

endmodule

// File: tb/tb_bundle_decoder.sv
// tb_bundle_decoder
//   Directed bench for bundle_decoder with its default parameters
//   (N=10, WINDOW=16, HI=9, LO=1). Inputs are driven and outputs are sampled
//   1 ns after each rising edge. Each loop iteration c is one clock cycle. The
//   cycle in which start_i is raised is cycle 0.

module tb_bundle_decoder;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int TW = $clog2(N*W+1);
  localparam int EW = $clog2(W+1);

  logic           clk = 1'b0;
  logic           reset;
  logic           start_i;
  logic           expected_i;
  logic [N-1:0]   bundle_i;
  logic           busy_o;
  logic           done_o;
  logic           value_o;
  logic           undecided_o;
  logic [TW-1:0]  total_o;
  logic [EW-1:0]  sample_err_o;
`ifdef BUNDLE_DECODER_STATS_EN
  logic [15:0]    undecided_runs_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  bundle_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .expected_i   (expected_i),
    .bundle_i     (bundle_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .value_o      (value_o),
    .undecided_o  (undecided_o),
    .total_o      (total_o),
    .sample_err_o (sample_err_o)
`ifdef BUNDLE_DECODER_STATS_EN
    ,
    .undecided_runs_o (undecided_runs_o)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] make_bundle(input int k);
    logic [N-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) if (i < k) b[i] = 1'b1;
    return b;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Driver for one window. It is called in the cycle that is to raise
  // start_i (cycle 0). Sample i (cycle i+1) carries odd_ones lines if
  // i == odd_idx, and base lines otherwise. After acceptance expected_i is
  // flipped, and start_i is pulsed again in cycle pulse_at.
  task automatic run_window(input string name, input logic exp, input int base,
                            input int odd_idx, input int odd_ones, input int pulse_at,
                            input int e_total, input logic e_value,
                            input logic e_undec, input int e_err);
    int done_cnt, done_cyc, busy_bad;
    logic [TW-1:0] tot_d;
    logic [EW-1:0] err_d;
    logic val_d, und_d;
    done_cnt = 0; done_cyc = -1; busy_bad = 0;
    tot_d = '0; err_d = '0; val_d = 1'b0; und_d = 1'b0;
    start_i    = 1'b1;
    expected_i = exp;
    bundle_i   = '0;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if (done_o) begin
        done_cnt++;
        done_cyc = c;
        tot_d = total_o; err_d = sample_err_o; val_d = value_o; und_d = undecided_o;
      end
      if (busy_o !== ((c >= 1) && (c <= W + 1))) busy_bad++;
      start_i    = (c == pulse_at);
      expected_i = ~exp;
      bundle_i   = (c <= W) ? make_bundle((c - 1 == odd_idx) ? odd_ones : base) : '0;
    end
    start_i = 1'b0;
    check({name, ".done_count"}, done_cnt, 1);
    check({name, ".done_cycle"}, done_cyc, W + 1);
    check({name, ".busy_profile_errors"}, busy_bad, 0);
    check({name, ".total"}, tot_d, e_total);
    check({name, ".value"}, val_d, e_value);
    check({name, ".undecided"}, und_d, e_undec);
    check({name, ".sample_err"}, err_d, e_err);
    check({name, ".total_held"}, total_o, e_total);
  endtask

  initial begin
    int saw_done;
    reset = 1'b1; start_i = 1'b0; expected_i = 1'b0; bundle_i = '0;
    repeat (3) next_cycle();
    check("reset.busy", busy_o, 0);
    check("reset.done", done_o, 0);
    check("reset.value", value_o, 0);
    check("reset.undecided", undecided_o, 0);
    check("reset.total", total_o, 0);
    check("reset.sample_err", sample_err_o, 0);
`ifdef BUNDLE_DECODER_STATS_EN
    check("reset.runs", undecided_runs_o, 0);
`endif
    reset = 1'b0;
    next_cycle();

    //          name       exp  base odd  oddn pulse total val und err
    run_window("ones",     1'b1, 10, -1,  0,  5,   160, 1'b1, 1'b0, 0);
    run_window("zeros",    1'b1,  0, -1,  0, 17,     0, 1'b0, 1'b0, 16);
    run_window("five_e0",  1'b0,  5, -1,  0,  0,    80, 1'b0, 1'b1, 16);
    run_window("nine",     1'b1,  9, -1,  0,  0,   144, 1'b1, 1'b0, 0);
    run_window("one",      1'b0,  1, -1,  0,  0,    16, 1'b0, 1'b0, 0);
    run_window("one_eight",1'b1, 10,  3,  8,  0,   158, 1'b1, 1'b0, 1);
    run_window("five_e1",  1'b1,  5, -1,  0,  0,    80, 1'b0, 1'b1, 16);
    run_window("two_e0",   1'b0,  2, -1,  0,  0,    32, 1'b0, 1'b1, 16);
`ifdef BUNDLE_DECODER_STATS_EN
    check("stats.runs", undecided_runs_o, 3);
`endif

    // Abort a window with reset in cycle 8, then restart in cycle 10.
    saw_done   = 0;
    start_i    = 1'b1;
    expected_i = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      if (done_o) saw_done++;
      start_i  = 1'b0;
      bundle_i = make_bundle(10);
      reset    = (c == 8);
    end
    check("abort.no_done", saw_done, 0);
    check("abort.busy", busy_o, 0);
    check("abort.value", value_o, 0);
    check("abort.undecided", undecided_o, 0);
    check("abort.total", total_o, 0);
    check("abort.sample_err", sample_err_o, 0);
`ifdef BUNDLE_DECODER_STATS_EN
    check("abort.runs", undecided_runs_o, 0);
`endif
    next_cycle();
    run_window("restart",  1'b1, 10, -1,  0,  0,   160, 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
